// File: rtl/tc_io_pkg.sv
// Shared definitions for the TinyComp I/O-bus UART: register offsets, status bit
// positions, FSM state encodings and the STATUS register layout.
package tc_io_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;

  localparam int unsigned STAT_RX_NE   = 0;
  localparam int unsigned STAT_TX_FULL = 1;
  localparam int unsigned STAT_TX_BUSY = 2;
  localparam int unsigned STAT_RXOVF   = 3;
  localparam int unsigned STAT_TXOVF   = 4;
  localparam int unsigned STAT_FERR    = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Member order matches the STAT_* bit positions (ferr is the MSB).
  typedef struct packed {
    logic ferr;
    logic txovf;
    logic rxovf;
    logic tx_busy;
    logic tx_full;
    logic rx_ne;
  } uart_status_t;

  function automatic logic [31:0] status_word(input uart_status_t s);
    return {26'b0, s};
  endfunction

endpackage

// File: rtl/tc_uart_if.sv
// TinyComp I/O bus as seen by one responder: CPU Input/Output instruction signals.
interface tc_uart_if;

  logic [31:0] IOaddr;
  logic        InStrobe;
  logic [31:0] InData;
  logic        InRdy;
  logic        OutStrobe;
  logic [31:0] OutData;

  modport master (
    output IOaddr, InStrobe, OutStrobe, OutData,
    input  InData, InRdy
  );

  modport slave (
    input  IOaddr, InStrobe, OutStrobe, OutData,
    output InData, InRdy
  );

endinterface

// File: rtl/tc_fifo.sv
// Synchronous byte FIFO with a look-ahead head; a push on a full FIFO is accepted
// only when a pop happens on the same edge.
module tc_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push_c;
  logic          do_pop_c;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign head      = mem[rd_ptr];
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tc_uart.sv
// Memory-mapped 8N1 UART responding on the TinyComp I/O bus, with TX and RX FIFOs
// so the CPU can poll with skip-on-InRdy.
module tc_uart
  import tc_io_pkg::*;
#(
  parameter logic [31:0] BASE         = 32'h0000_0000,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic          Ph0,
  input  logic          Reset,
  tc_uart_if.slave      bus,
  output logic          TxD,
  input  logic          RxD
);

  localparam int unsigned     CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  // Bus decode and strobe qualification
  logic sel_c, data_sel_c, stat_sel_c;
  logic tx_push_c, rx_pop_c, stat_rd_c;
  logic tx_pop_c, tx_full, tx_empty;
  logic rx_push_c, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;

  assign sel_c      = (bus.IOaddr[31:2] == BASE[31:2]);
  assign data_sel_c = sel_c && (bus.IOaddr[1:0] == UART_DATA);
  assign stat_sel_c = sel_c && (bus.IOaddr[1:0] == UART_STATUS);
  assign tx_push_c  = bus.OutStrobe && data_sel_c;
  assign rx_pop_c   = bus.InStrobe && data_sel_c && !rx_empty;
  assign stat_rd_c  = bus.InStrobe && stat_sel_c;

  logic unused_c;
  assign unused_c = ^{bus.OutData[31:8], BASE[1:0]};

  logic [7:0] rx_shift;

  tc_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (Ph0),
    .rst_n (Reset),
    .push  (tx_push_c),
    .pop   (tx_pop_c),
    .din   (bus.OutData[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  tc_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (Ph0),
    .rst_n (Reset),
    .push  (rx_push_c),
    .pop   (rx_pop_c),
    .din   (rx_shift),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // ---------------- Transmitter ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, tx_shift_nxt_c;
  logic          txd, txd_nxt_c;
  logic          tx_last_c;

  assign tx_last_c = (tx_cnt == CNT_LAST);

  always_ff @(posedge Ph0 or negedge Reset) begin
    if (!Reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_last_c) tx_next = TX_DATA;
      TX_DATA:  if (tx_last_c && (tx_bit == 3'd7)) tx_next = TX_STOP;
      TX_STOP:  if (tx_last_c) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Line level is computed from the next state so TxD is a clean flop output.
  always_comb begin
    tx_pop_c       = 1'b0;
    tx_shift_nxt_c = tx_shift;
    txd_nxt_c      = 1'b1;
    if (((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_last_c)) && !tx_empty) begin
      tx_pop_c       = 1'b1;
      tx_shift_nxt_c = tx_head;
    end else if ((tx_state == TX_DATA) && tx_last_c) begin
      tx_shift_nxt_c = {1'b0, tx_shift[7:1]};
    end
    case (tx_next)
      TX_START: txd_nxt_c = 1'b0;
      TX_DATA:  txd_nxt_c = tx_shift_nxt_c[0];
      default:  txd_nxt_c = 1'b1;
    endcase
  end

  always_ff @(posedge Ph0 or negedge Reset) begin
    if (!Reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      txd      <= txd_nxt_c;
      tx_shift <= tx_shift_nxt_c;
      if (tx_state == TX_IDLE) tx_cnt <= '0;
      else                     tx_cnt <= tx_last_c ? '0 : tx_cnt + CW'(1);
      if (tx_state != TX_DATA)  tx_bit <= '0;
      else if (tx_last_c)       tx_bit <= tx_bit + 3'd1;
    end
  end

  assign TxD = txd;

  // ---------------- Receiver ----------------
  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_last_c, rx_mid_c, rx_sample_c, ferr_set_c;

  always_ff @(posedge Ph0 or negedge Reset) begin
    if (!Reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], RxD};
  end

  assign rx_s      = rx_sync[1];
  assign rx_last_c = (rx_cnt == CNT_LAST);
  assign rx_mid_c  = (rx_cnt == CNT_MID);

  always_ff @(posedge Ph0 or negedge Reset) begin
    if (!Reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (rx_mid_c) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_last_c && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_last_c) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_sample_c = 1'b0;
    rx_push_c   = 1'b0;
    ferr_set_c  = 1'b0;
    case (rx_state)
      RX_DATA: rx_sample_c = rx_last_c;
      RX_STOP: begin
        rx_push_c  = rx_last_c && rx_s;
        ferr_set_c = rx_last_c && !rx_s;
      end
      default: ;
    endcase
  end

  // The idle-exit edge counts as the first cycle of the start bit, so the
  // mid-start sample lands half a bit after the synchronized falling edge.
  always_ff @(posedge Ph0 or negedge Reset) begin
    if (!Reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= rx_s ? '0 : CW'(1);
          rx_bit <= '0;
        end
        RX_START: rx_cnt <= rx_mid_c ? '0 : rx_cnt + CW'(1);
        default:  rx_cnt <= rx_last_c ? '0 : rx_cnt + CW'(1);
      endcase
      if (rx_sample_c) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- Sticky flags and read mux ----------------
  logic ferr, txovf, rxovf;
  logic txovf_set_c, rxovf_set_c;

  assign txovf_set_c = tx_push_c && tx_full && !tx_pop_c;
  assign rxovf_set_c = rx_push_c && rx_full && !rx_pop_c;

  always_ff @(posedge Ph0 or negedge Reset) begin
    if (!Reset) begin
      ferr  <= 1'b0;
      txovf <= 1'b0;
      rxovf <= 1'b0;
    end else begin
      ferr  <= ferr_set_c  | (ferr  & ~stat_rd_c);
      txovf <= txovf_set_c | (txovf & ~stat_rd_c);
      rxovf <= rxovf_set_c | (rxovf & ~stat_rd_c);
    end
  end

  uart_status_t st_c;
  logic [31:0]  in_data_c;
  logic         in_rdy_c;

  always_comb begin
    st_c.ferr    = ferr;
    st_c.txovf   = txovf;
    st_c.rxovf   = rxovf;
    st_c.tx_busy = !tx_empty || (tx_state != TX_IDLE);
    st_c.tx_full = tx_full;
    st_c.rx_ne   = !rx_empty;
  end

  always_comb begin
    in_data_c = '0;
    in_rdy_c  = 1'b0;
    if (data_sel_c) begin
      in_rdy_c = !rx_empty;
      if (!rx_empty) in_data_c = {24'b0, rx_head};
    end else if (stat_sel_c) begin
      in_rdy_c  = !tx_full;
      in_data_c = status_word(st_c);
    end
  end

  assign bus.InData = in_data_c;
  assign bus.InRdy  = in_rdy_c;

endmodule

// File: tb/tb_tc_uart.sv
// Directed-plus-random bench for tc_uart: TX waveforms against frame rules, RX and
// loopback bytes against a queue model, status flags against their set/clear rules.
module tb_tc_uart;
  import tc_io_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0040;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_0000;

  logic Ph0;
  logic Reset;
  logic TxD;
  logic RxD;
  logic rxd_drv;
  logic loop;

  tc_uart_if bus ();

  assign RxD = loop ? TxD : rxd_drv;

  tc_uart #(.BASE(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Ph0   (Ph0),
    .Reset (Reset),
    .bus   (bus),
    .TxD   (TxD),
    .RxD   (RxD)
  );

  initial Ph0 = 1'b0;
  always #5 Ph0 = ~Ph0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  rxq [$];
  logic [31:0] d;
  logic        r;
  logic [7:0]  b;
  logic [7:0]  exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Ph0);
      #1;
    end
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    bus.IOaddr = addr;
    #1;
    data = bus.InData;
    rdy  = bus.InRdy;
  endtask

  task automatic io_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    bus.IOaddr   = addr;
    bus.InStrobe = 1'b1;
    #1;
    data = bus.InData;
    rdy  = bus.InRdy;
    cyc(1);
    bus.InStrobe = 1'b0;
    bus.IOaddr   = IDLE_ADDR;
  endtask

  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    bus.IOaddr    = addr;
    bus.OutData   = data;
    bus.OutStrobe = 1'b1;
    cyc(1);
    bus.OutStrobe = 1'b0;
    bus.IOaddr    = IDLE_ADDR;
  endtask

  // Called right after the write edge: line stays idle one cycle, then start, 8 data LSB first, stop.
  task automatic tx_expect(input logic [7:0] byte_v, input string tag);
    logic [9:0] frame;
    frame = {1'b1, byte_v, 1'b0};
    check({tag, "_pre"}, 32'(TxD), 32'd1);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        cyc(1);
        check(tag, 32'(TxD), 32'(frame[i]));
      end
    end
  endtask

  // A bad stop bit is held low just past mid-bit so the line is idle again soon after.
  task automatic send_frame(input logic [7:0] byte_v, input logic stop_ok);
    rxd_drv = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = byte_v[i];
      cyc(CPB);
    end
    if (stop_ok) begin
      rxd_drv = 1'b1;
      cyc(CPB);
    end else begin
      rxd_drv = 1'b0;
      cyc(CPB / 2 + 1);
      rxd_drv = 1'b1;
      cyc(CPB - (CPB / 2 + 1));
    end
  endtask

  task automatic drain_rx(input string tag);
    while (rxq.size() > 0) begin
      exp_b = rxq.pop_front();
      io_read(BASE, d, r);
      check({tag, "_rdy"}, 32'(r), 32'd1);
      check({tag, "_data"}, d, {24'b0, exp_b});
    end
    peek(BASE, d, r);
    check({tag, "_empty_rdy"}, 32'(r), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [4];
    logic [31:0] st_exp;
    int guard;

    Reset         = 1'b0;
    loop          = 1'b0;
    rxd_drv       = 1'b1;
    bus.IOaddr    = IDLE_ADDR;
    bus.InStrobe  = 1'b0;
    bus.OutStrobe = 1'b0;
    bus.OutData   = '0;
    cyc(3);
    check("txd_in_reset", 32'(TxD), 32'd1);
    Reset = 1'b1;
    cyc(2);

    // Reset state
    io_read(BASE + 32'd1, d, r);
    check("rst_status_data", d, 32'd0);
    check("rst_status_rdy", 32'(r), 32'd1);
    check("rst_txd", 32'(TxD), 32'd1);
    peek(BASE, d, r);
    check("rst_data_rdy", 32'(r), 32'd0);
    check("rst_data_val", d, 32'd0);

    addrs[0] = BASE + 32'd2;
    addrs[1] = BASE + 32'd3;
    addrs[2] = BASE + 32'd4;
    addrs[3] = BASE - 32'd3;
    for (int i = 0; i < 4; i++) begin
      peek(addrs[i], d, r);
      check("unsel_data", d, 32'd0);
      check("unsel_rdy", 32'(r), 32'd0);
    end

    // Output to STATUS has no effect
    io_write(BASE + 32'd1, 32'h0000_00FF);
    cyc(3);
    check("stat_wr_txd", 32'(TxD), 32'd1);
    io_read(BASE + 32'd1, d, r);
    check("stat_wr_status", d, 32'd0);

    // Only the low byte of OutData is transmitted
    io_write(BASE, 32'h0000_01A5);
    tx_expect(8'hA5, "tx_a5");
    cyc(1);
    check("tx_a5_idle", 32'(TxD), 32'd1);
    io_read(BASE + 32'd1, d, r);
    check("tx_a5_status", d, 32'd0);

    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      io_write(BASE, {24'($urandom), b});
      tx_expect(b, "tx_rand");
      cyc(1);
    end

    // Loopback
    loop = 1'b1;
    io_write(BASE, 32'h0000_003C);
    rxq.push_back(8'h3C);
    cyc(10 * CPB + 6);
    drain_rx("loop_3c");

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      rxq.push_back(b);
      io_write(BASE, {24'h0, b});
    end
    cyc(6 * 10 * CPB + 20);
    drain_rx("loop_burst");
    loop = 1'b0;

    // TX overflow: first byte goes to the shifter, next DEPTH fill the FIFO, last is dropped
    for (int k = 0; k < int'(DEPTH) + 2; k++) io_write(BASE, $urandom);
    st_exp = (32'd1 << STAT_TXOVF) | (32'd1 << STAT_TX_BUSY) | (32'd1 << STAT_TX_FULL);
    io_read(BASE + 32'd1, d, r);
    check("txovf_status1", d, st_exp);
    check("txovf_rdy", 32'(r), 32'd0);
    io_read(BASE + 32'd1, d, r);
    check("txovf_status2", d, st_exp & ~(32'd1 << STAT_TXOVF));
    guard = 0;
    do begin
      io_read(BASE + 32'd1, d, r);
      guard++;
    end while (d[STAT_TX_BUSY] && guard < 2000);
    check("tx_drain_status", d, 32'd0);

    // Random frames straight onto RxD with small idle gaps
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      rxq.push_back(b);
      send_frame(b, 1'b1);
      rxd_drv = 1'b1;
      cyc($urandom_range(3, 0));
    end
    cyc(CPB + 4);
    drain_rx("rx_rand");

    // RX overflow: DEPTH+1 frames with no reads in between
    for (int k = 0; k < int'(DEPTH) + 1; k++) begin
      b = 8'($urandom);
      if (k < int'(DEPTH)) rxq.push_back(b);
      send_frame(b, 1'b1);
    end
    cyc(CPB + 4);
    io_read(BASE + 32'd1, d, r);
    check("rxovf_status", d, (32'd1 << STAT_RXOVF) | (32'd1 << STAT_RX_NE));
    drain_rx("rxovf");

    // Framing error
    send_frame(8'h55, 1'b0);
    cyc(4 * CPB);
    peek(BASE, d, r);
    check("ferr_rdy", 32'(r), 32'd0);
    io_read(BASE + 32'd1, d, r);
    check("ferr_status", d, 32'd1 << STAT_FERR);
    io_read(BASE + 32'd1, d, r);
    check("ferr_cleared", d, 32'd0);

    // One-cycle glitch is not a start bit
    rxd_drv = 1'b0;
    cyc(1);
    rxd_drv = 1'b1;
    cyc(10 * CPB + 5);
    peek(BASE, d, r);
    check("glitch_rdy", 32'(r), 32'd0);
    io_read(BASE + 32'd1, d, r);
    check("glitch_status", d, 32'd0);

    // Reset mid-frame on both paths
    io_write(BASE, 32'h0000_0000);
    rxd_drv = 1'b0;
    cyc(12);
    check("mid_frame_txd", 32'(TxD), 32'd0);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_txd", 32'(TxD), 32'd1);
    cyc(2);
    rxd_drv = 1'b1;
    Reset   = 1'b1;
    cyc(12 * CPB);
    io_read(BASE + 32'd1, d, r);
    check("post_rst_status", d, 32'd0);
    peek(BASE, d, r);
    check("post_rst_rdy", 32'(r), 32'd0);
    check("post_rst_txd", 32'(TxD), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tc_uart.md
# tc_uart

Memory-mapped 8N1 serial port that is the responder on the TinyComp I/O bus. It answers the CPU's Input instructions (InStrobe, InData, InRdy) and accepts its Output instructions (OutStrobe, OutData), addressed by IOaddr. Transmit and receive paths each have a FIFO, so the CPU polls with skip-on-InRdy instead of busy-waiting on the line.

## Interface
- BASE, 32'h0000_0000: I/O base address. Bits [1:0] must be 0.
- CLKS_PER_BIT, 434: Ph0 cycles per serial bit. Legal values are ≥ 4.
- FIFO_DEPTH, 16: entries per FIFO. Must be a power of 2, ≥ 2.
- Ph0  in  1  clock. The same Ph0 that clocks the CPU PC.
- Reset  in  1  asynchronous, active-low reset.
- IOaddr  in  32  I/O address from the CPU.
- InStrobe  in  1  CPU is executing an Input instruction this cycle.
- InData  out  32  read data. Combinational.
- InRdy  out  1  ready flag for the skip test. Combinational.
- OutStrobe  in  1  CPU is executing an Output instruction this cycle.
- OutData  in  32  write data.
- TxD  out  1  serial out. Idles high.
- RxD  in  1  serial in. Asynchronous to Ph0.

## Operation
- Select: sel = (IOaddr[31:2] == BASE[31:2]). Offset is IOaddr[1:0].
- Offset 0, DATA:
  - Out writes OutData[7:0] into the TX FIFO. If the TX FIFO is full, the byte is dropped and txovf is set.
  - In returns {24'b0, RX head} and pops the RX FIFO. If the RX FIFO is empty, it returns 0 and does not pop.
  - InRdy = RX FIFO not empty.
- Offset 1, STATUS:
  - In returns {26'b0, ferr, txovf, rxovf, tx_busy, tx_full, rx_ne}.
  - Reading STATUS clears ferr, txovf and rxovf.
  - InRdy = TX FIFO not full.
  - Out to STATUS is ignored.
- Offsets 2–3 and unselected addresses: InData = 0, InRdy = 0, no side effects.
- Strobes take effect on the Ph0 rising edge that ends the instruction, i.e. with strobe=1 and sel=1.
- tx_busy = TX FIFO not empty OR TX FSM not in IDLE.
- TX FSM: TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE.
  - TX_IDLE: when the FIFO is not empty, pop the byte into the shifter and go to TX_START.
  - Each state holds for CLKS_PER_BIT cycles. TX_DATA sends 8 bits, LSB first.
  - At the end of TX_STOP, if the FIFO is not empty, go directly to TX_START with the next byte. No idle gap.
- RX path: RxD passes through a 2-flop synchronizer, reset value 1.
- RX FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - RX_IDLE: a synchronized low starts the counter and moves to RX_START.
  - RX_START: sample at CLKS_PER_BIT/2. If the line is high, the start was a glitch; return to RX_IDLE.
  - RX_DATA: sample 8 bits, one every CLKS_PER_BIT cycles from mid-start. LSB first.
  - RX_STOP: sample mid-stop. If high, push the byte. If low, discard the byte and set ferr. Then return to RX_IDLE.
- RX push when the FIFO is full:
  - If a CPU DATA read pops on the same edge, the push succeeds.
  - Otherwise the byte is dropped and rxovf is set.
- Set and clear of a sticky flag on the same edge: set wins.
- Reset values: TxD = 1; both FSMs in IDLE; FIFOs empty; all flags 0. InData and InRdy are combinational, so both are 0 unless the address is selected.

## Timing
- A TX write on edge N makes TxD fall on edge N+1 if the transmitter was idle.
- A TX frame is exactly 10·CLKS_PER_BIT cycles.
- The RX byte is visible, with InRdy = 1 at DATA, in the cycle after the edge that samples mid-stop.
- Line-to-FIFO latency: 2 cycles of synchronizer plus 9.5 bit times from the falling edge of the start bit.
- FIFO push and pop on the same edge: both occur, and the count is unchanged.
- Bit counters are $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT−1.
- Asserting Reset mid-frame aborts both FSMs immediately.
  - TxD returns to 1 asynchronously.
  - Partial RX bytes are discarded.

## Structure
- Package tc_io_pkg holds:
  - offset constants UART_DATA = 0 and UART_STATUS = 1;
  - status bit indices;
  - tx_state_t and rx_state_t enums.
- Sub-module tc_fifo: synchronous FIFO, 8 bits wide, FIFO_DEPTH deep, with push, pop, full, empty and head outputs. It is instantiated once for TX and once for RX.

## Test plan
- Reset, then IOaddr = BASE+1 with InStrobe: InData = 0, InRdy = 1, TxD = 1. At IOaddr = BASE: InRdy = 0.
- CLKS_PER_BIT = 4, Out 0x1A5 to BASE: TxD falls one cycle later. It then holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles. Only 0xA5 is sent.
- Loop TxD back to RxD, Out 0x3C: after the frame, InRdy = 1 at BASE. The In returns 0x0000003C, and InRdy then drops to 0.
- FIFO_DEPTH = 16, 18 back-to-back Outs: byte 1 enters the shifter, bytes 2–17 fill the FIFO, byte 18 is dropped. STATUS reads 0x16 (txovf, tx_busy, tx_full). A second STATUS read gives 0x06.
- Drive a frame 0x55 with the stop bit low: no push, InRdy at BASE stays 0, STATUS bit 5 = 1.
- A 1-cycle low glitch on RxD: the RX FSM returns to RX_IDLE, and neither a push nor ferr occurs.
